// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, 1-entry hold buffer for stalls and branch redirect.
// Optional stall-cycle counter on freeze_cnt when FETCH_STALL_CNT_EN is defined.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_valid
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       freeze_cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [DATA_W-1:0] hold_instr_q, hold_instr_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if_valid_d   = if_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;

        // A redirect outranks stall and memory response; the hold buffer is simply abandoned.
        if (state_q != S_BOOT && branch_taken) begin
            pc_d       = branch_addr;
            if_valid_d = 1'b0;
            state_d    = S_FETCH;
        end else begin
            unique case (state_q)
                S_BOOT: begin
                    if (branch_taken) begin
                        pc_d = branch_addr;
                    end
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_q + ADDR_W'(4);
                        if (freeze) begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = imem_rdata;
                            state_d      = S_HOLD;
                        end else begin
                            if_pc_d    = pc_q + ADDR_W'(4);
                            if_instr_d = imem_rdata;
                            if_valid_d = 1'b1;
                        end
                    end else if (!freeze) begin
                        if_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        if_pc_d    = hold_pc_q + ADDR_W'(4);
                        if_instr_d = hold_instr_q;
                        if_valid_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end

        req_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            if_valid_q   <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pc_q         <= pc_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_valid_q   <= if_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_valid  = if_valid_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating: a long stall must never wrap back to a small count.
    always_comb begin
        cnt_d = cnt_q;
        if (freeze && state_q != S_BOOT && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign freeze_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] freeze_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_valid     (if_valid)
`ifdef FETCH_STALL_CNT_EN
        ,
        .freeze_cnt   (freeze_cnt)
`endif
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // Reference model: pipeline register contents, PC, and a queue of instructions parked by a stall.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } held_t;

    held_t       held_q[$];
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_instr;
    bit          m_if_valid;
    bit [15:0]   m_cnt;

    task automatic model_reset();
        held_q.delete();
        m_boot     = 1'b1;
        m_pc       = 32'h0;
        m_if_pc    = 32'h0;
        m_if_instr = 32'h0;
        m_if_valid = 1'b0;
        m_cnt      = 16'h0;
    endtask

    task automatic model_step(input bit fr, input bit rdy, input bit br, input logic [31:0] ba);
        held_t h;
        if (m_boot) begin
            if (br) m_pc = ba;
            m_boot = 1'b0;
            return;
        end
        if (fr && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (br) begin
            m_pc       = ba;
            m_if_valid = 1'b0;
            held_q.delete();
        end else if (held_q.size() != 0) begin
            if (!fr) begin
                h          = held_q.pop_front();
                m_if_pc    = h.pc + 32'd4;
                m_if_instr = h.instr;
                m_if_valid = 1'b1;
            end
        end else if (rdy) begin
            if (fr) begin
                h.pc    = m_pc;
                h.instr = mem_word(m_pc);
                held_q.push_back(h);
            end else begin
                m_if_pc    = m_pc + 32'd4;
                m_if_instr = mem_word(m_pc);
                m_if_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!fr) begin
            m_if_valid = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model, then settle 1ns past the edge.
    task automatic cyc(input bit fr, input bit rdy, input bit br, input logic [31:0] ba);
        freeze       = fr;
        imem_ready   = rdy;
        branch_taken = br;
        branch_addr  = ba;
        imem_rdata   = mem_word(imem_addr);
        model_step(fr, rdy, br, ba);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        freeze       = 1'b0;
        imem_ready   = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc got=%h want=0", if_pc); end
        total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL reset_if_instr got=%h want=0", if_instr); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
        do_reset();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b want=0", imem_req); end
        cyc(0, 0, 0, 0);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_addr !== 32'(4 * i)) begin
                bad++; $display("FAIL zw_addr i=%0d got=%h want=%h", i, imem_addr, 32'(4 * i));
            end
            cyc(0, 1, 0, 0);
            total++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * (i + 1)) || if_instr !== mem_word(32'(4 * i))) begin
                bad++; $display("FAIL zw_ifid i=%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                                i, if_valid, if_pc, if_instr, 32'(4 * (i + 1)), mem_word(32'(4 * i)));
            end
        end
    endtask

    task automatic test_wait2();
        int nrdy;
        bit rdy;
        do_reset();
        cyc(0, 0, 0, 0);
        nrdy = 0;
        for (int k = 0; k < 6; k++) begin
            rdy = (k % 3 == 2);
            cyc(0, rdy, 0, 0);
            if (rdy) nrdy++;
            total++; if (if_valid !== rdy || imem_addr !== 32'(4 * nrdy)) begin
                bad++; $display("FAIL wait2 k=%0d got v=%b addr=%h want v=%b addr=%h",
                                k, if_valid, imem_addr, rdy, 32'(4 * nrdy));
            end
        end
    endtask

    task automatic test_freeze_hold();
        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0, 0);
            total++; if (imem_req !== 1'b0 || if_pc !== 32'd8 || if_instr !== mem_word(32'd4) || if_valid !== 1'b1) begin
                bad++; $display("FAIL hold k=%0d got req=%b pc=%h ins=%h v=%b want req=0 pc=8 ins=%h v=1",
                                k, imem_req, if_pc, if_instr, if_valid, mem_word(32'd4));
            end
        end
        cyc(0, 0, 0, 0);
        total++; if (if_pc !== 32'd12 || if_instr !== mem_word(32'd8) || if_valid !== 1'b1) begin
            bad++; $display("FAIL release got pc=%h ins=%h v=%b want pc=c ins=%h v=1", if_pc, if_instr, if_valid, mem_word(32'd8));
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin
            bad++; $display("FAIL release_req got req=%b addr=%h want req=1 addr=c", imem_req, imem_addr);
        end
    endtask

    task automatic test_branch_in_hold();
        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 32'h100);
        total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++; $display("FAIL br_hold got v=%b req=%b addr=%h want v=0 req=1 addr=100", if_valid, imem_req, imem_addr);
        end
        cyc(0, 1, 0, 0);
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_instr !== mem_word(32'h100)) begin
            bad++; $display("FAIL br_first got v=%b pc=%h ins=%h want v=1 pc=104 ins=%h", if_valid, if_pc, if_instr, mem_word(32'h100));
        end
        cyc(0, 1, 0, 0);
        total++; if (if_pc !== 32'h108) begin
            bad++; $display("FAIL br_drop got pc=%h want pc=108", if_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_addr0 got=%h want=fffffffc", imem_addr);
        end
        cyc(0, 1, 0, 0);
        total++; if (imem_addr !== 32'h0 || if_pc !== 32'h0 || if_valid !== 1'b1 || if_instr !== mem_word(32'hFFFF_FFFC)) begin
            bad++; $display("FAIL wrap got addr=%h pc=%h v=%b ins=%h want addr=0 pc=0 v=1 ins=%h",
                            imem_addr, if_pc, if_valid, if_instr, mem_word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_valid !== 1'b0) begin
            bad++; $display("FAIL async_rst got req=%b addr=%h pc=%h ins=%h v=%b want all 0",
                            imem_req, imem_addr, if_pc, if_instr, if_valid);
        end
`ifdef FETCH_STALL_CNT_EN
        total++; if (freeze_cnt !== 16'h0) begin bad++; $display("FAIL async_rst_cnt got=%0d want=0", freeze_cnt); end
`endif
        do_reset();
    endtask

`ifdef FETCH_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0);
        total++; if (freeze_cnt !== 16'd5) begin bad++; $display("FAIL stall_cnt got=%0d want=5", freeze_cnt); end
    endtask
`endif

    task automatic test_random();
        bit          fr, rdy, br;
        logic [31:0] ba;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            fr  = ($urandom_range(0, 9) < 3);
            rdy = ($urandom_range(0, 9) < 6);
            br  = ($urandom_range(0, 19) == 0);
            ba  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : {$urandom(), 2'b00} & 32'h0000_0FFC;
            cyc(fr, rdy, br, ba);
            total++; if (imem_req !== (!m_boot && held_q.size() == 0)) begin
                bad++; $display("FAIL rnd_req n=%0d got=%b want=%b", n, imem_req, (!m_boot && held_q.size() == 0));
            end
            total++; if (imem_addr !== m_pc) begin
                bad++; $display("FAIL rnd_addr n=%0d got=%h want=%h", n, imem_addr, m_pc);
            end
            total++; if (if_valid !== m_if_valid || if_pc !== m_if_pc || if_instr !== m_if_instr) begin
                bad++; $display("FAIL rnd_ifid n=%0d got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h",
                                n, if_valid, if_pc, if_instr, m_if_valid, m_if_pc, m_if_instr);
            end
`ifdef FETCH_STALL_CNT_EN
            total++; if (freeze_cnt !== m_cnt) begin
                bad++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, freeze_cnt, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait2();
        test_freeze_hold();
        test_branch_in_hold();
        test_wrap();
        test_async_reset();
`ifdef FETCH_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
